// File: rtl/udp_echo_responder.sv
// udp_echo_responder: captures one IPv4/UDP datagram and replays it as a reply with addresses/ports swapped, TTL rewritten and checksums fixed up
module udp_echo_responder #(
    parameter int         DEPTH     = 256,
    parameter int         ADDR_W    = 8,
    parameter logic [7:0] REPLY_TTL = 8'h40
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] rx,
    input  logic       rx_valid,
    input  logic       rx_first,
    input  logic       rx_last,
    output logic [7:0] tx,
    output logic       tx_valid,
    output logic       tx_first,
    output logic       tx_last,
    input  logic       tx_ready,
    output logic       busy,
    output logic       rx_drop,
    output logic [7:0] drop_count
);
    localparam int CW = ADDR_W + 1;
    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

    typedef enum logic [2:0] {IDLE, CAPTURE, CSUM, SEND, DROP} state_t;

    state_t        r_state;
    logic [7:0]    r_mem [DEPTH];
    logic [CW-1:0] r_count, r_rd_ptr;
    logic [15:0]   r_len, r_src_port, r_dst_port, r_csum;
    logic [31:0]   r_src_ip, r_dst_ip;
    logic [19:0]   r_acc;
    logic [7:0]    r_tx, r_drop_count;
    logic          r_tx_valid, r_tx_first, r_tx_last, r_rx_drop;

    logic          w_start, w_restart, w_collide, w_cap, w_bad, w_wr_hdr, w_rd_hdr, w_handshake, w_load;
    logic [CW-1:0] w_off, w_cnt;
    logic [4:0]    w_wr_lo, w_rd_lo;
    logic [7:0]    w_acc_byte, w_rd_byte, w_tx_byte;
    logic [19:0]   w_acc_add;
    logic [16:0]   w_s1;
    logic [15:0]   w_s2;
    logic [1:0]    w_drops;
    logic [8:0]    w_dc_sum;

    // Capture-side decode: byte offset, fault detection, checksum term and drop accounting
    always_comb begin
        w_start     = rx_valid && rx_first && (r_state == IDLE || r_state == CAPTURE || r_state == DROP);
        w_restart   = rx_valid && rx_first && r_state == CAPTURE;
        w_collide   = rx_valid && rx_first && (r_state == CSUM || r_state == SEND);
        w_cap       = w_start || (rx_valid && r_state == CAPTURE);
        w_off       = w_start ? '0 : r_count;
        w_cnt       = w_off + 1'b1;
        w_wr_hdr    = w_off < CW'(32);
        w_wr_lo     = w_off[4:0];
        w_bad       = w_cap && ((w_off == '0 && rx != 8'h45) ||
                                (w_wr_hdr && w_wr_lo == 5'd9 && rx != 8'h11) ||
                                w_off == C_DEPTH ||
                                (rx_last && (w_cnt < CW'(28) || 16'(w_cnt) != r_len)));
        w_acc_byte  = (w_wr_lo == 5'd8) ? REPLY_TTL : (w_wr_lo == 5'd10 || w_wr_lo == 5'd11) ? 8'h00 : rx;
        w_acc_add   = w_off[0] ? {12'h000, w_acc_byte} : {4'h0, w_acc_byte, 8'h00};
        w_s1        = {1'b0, r_acc[15:0]} + {13'h0, r_acc[19:16]};
        w_s2        = w_s1[15:0] + {15'h0, w_s1[16]};
        w_rd_hdr    = r_rd_ptr < CW'(28);
        w_rd_lo     = r_rd_ptr[4:0];
        w_rd_byte   = r_mem[r_rd_ptr[ADDR_W-1:0]];
        w_handshake = r_tx_valid && tx_ready;
        w_load      = r_state == SEND && (!r_tx_valid || tx_ready) && !(w_handshake && r_tx_last);
        w_drops     = {1'b0, w_bad} + {1'b0, w_restart || w_collide};
        w_dc_sum    = {1'b0, r_drop_count} + {7'h0, w_drops};
    end

    // Reply byte substitution for the header fields that change in the echo
    always_comb begin
        w_tx_byte = w_rd_byte;
        if (w_rd_hdr) begin
            case (w_rd_lo)
                5'd8:    w_tx_byte = REPLY_TTL;
                5'd10:   w_tx_byte = r_csum[15:8];
                5'd11:   w_tx_byte = r_csum[7:0];
                5'd12:   w_tx_byte = r_dst_ip[31:24];
                5'd13:   w_tx_byte = r_dst_ip[23:16];
                5'd14:   w_tx_byte = r_dst_ip[15:8];
                5'd15:   w_tx_byte = r_dst_ip[7:0];
                5'd16:   w_tx_byte = r_src_ip[31:24];
                5'd17:   w_tx_byte = r_src_ip[23:16];
                5'd18:   w_tx_byte = r_src_ip[15:8];
                5'd19:   w_tx_byte = r_src_ip[7:0];
                5'd20:   w_tx_byte = r_dst_port[15:8];
                5'd21:   w_tx_byte = r_dst_port[7:0];
                5'd22:   w_tx_byte = r_src_port[15:8];
                5'd23:   w_tx_byte = r_src_port[7:0];
                5'd26:   w_tx_byte = 8'h00;
                5'd27:   w_tx_byte = 8'h00;
                default: w_tx_byte = w_rd_byte;
            endcase
        end
    end

    // Datagram buffer write; no reset needed since every byte is written before it is read
    always_ff @(posedge clk) begin
        if (w_cap && w_off != C_DEPTH) r_mem[w_off[ADDR_W-1:0]] <= rx;
    end

    // Main FSM: capture and validate, fold checksum, stream the reply with registered outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_count      <= '0;
            r_rd_ptr     <= '0;
            r_len        <= '0;
            r_src_port   <= '0;
            r_dst_port   <= '0;
            r_csum       <= '0;
            r_src_ip     <= '0;
            r_dst_ip     <= '0;
            r_acc        <= '0;
            r_tx         <= '0;
            r_tx_valid   <= 1'b0;
            r_tx_first   <= 1'b0;
            r_tx_last    <= 1'b0;
            r_rx_drop    <= 1'b0;
            r_drop_count <= '0;
        end else begin
            r_rx_drop    <= w_drops != 2'd0;
            r_drop_count <= w_dc_sum[8] ? 8'hFF : w_dc_sum[7:0];
            if (w_cap) begin
                r_count <= w_cnt;
                r_acc   <= (w_off == '0) ? w_acc_add : (w_wr_hdr && w_wr_lo < 5'd20) ? r_acc + w_acc_add : r_acc;
                if (w_wr_hdr) begin
                    case (w_wr_lo)
                        5'd2:    r_len[15:8]      <= rx;
                        5'd3:    r_len[7:0]       <= rx;
                        5'd12:   r_src_ip[31:24]  <= rx;
                        5'd13:   r_src_ip[23:16]  <= rx;
                        5'd14:   r_src_ip[15:8]   <= rx;
                        5'd15:   r_src_ip[7:0]    <= rx;
                        5'd16:   r_dst_ip[31:24]  <= rx;
                        5'd17:   r_dst_ip[23:16]  <= rx;
                        5'd18:   r_dst_ip[15:8]   <= rx;
                        5'd19:   r_dst_ip[7:0]    <= rx;
                        5'd20:   r_src_port[15:8] <= rx;
                        5'd21:   r_src_port[7:0]  <= rx;
                        5'd22:   r_dst_port[15:8] <= rx;
                        5'd23:   r_dst_port[7:0]  <= rx;
                        default: ;
                    endcase
                end
                r_state <= w_bad ? (rx_last ? IDLE : DROP) : (rx_last ? CSUM : CAPTURE);
            end else if (r_state == DROP && rx_valid && rx_last) begin
                r_state <= IDLE;
            end else if (r_state == CSUM) begin
                r_csum   <= ~w_s2;
                r_rd_ptr <= '0;
                r_state  <= SEND;
            end else if (r_state == SEND) begin
                if (w_handshake && r_tx_last) begin
                    r_tx       <= '0;
                    r_tx_valid <= 1'b0;
                    r_tx_first <= 1'b0;
                    r_tx_last  <= 1'b0;
                    r_state    <= IDLE;
                end else if (w_load) begin
                    r_tx       <= w_tx_byte;
                    r_tx_valid <= 1'b1;
                    r_tx_first <= r_rd_ptr == '0;
                    r_tx_last  <= 16'(r_rd_ptr) == r_len - 16'd1;
                    r_rd_ptr   <= r_rd_ptr + 1'b1;
                end
            end
        end
    end

    assign tx         = r_tx;
    assign tx_valid   = r_tx_valid;
    assign tx_first   = r_tx_first;
    assign tx_last    = r_tx_last;
    assign busy       = r_state != IDLE;
    assign rx_drop    = r_rx_drop;
    assign drop_count = r_drop_count;
endmodule

// File: tb/tb_udp_echo_responder.sv
// tb_udp_echo_responder: scoreboard bench for the UDP echo responder using directed frames
module tb_udp_echo_responder;
    logic       clk = 1'b0, reset_n = 1'b0;
    logic [7:0] rx = '0;
    logic       rx_valid = 1'b0, rx_first = 1'b0, rx_last = 1'b0, tx_ready = 1'b1;
    logic [7:0] tx, drop_count;
    logic       tx_valid, tx_first, tx_last, busy, rx_drop;

    always #5 clk = ~clk;

    udp_echo_responder dut (
        .clk(clk), .reset_n(reset_n), .rx(rx), .rx_valid(rx_valid), .rx_first(rx_first),
        .rx_last(rx_last), .tx(tx), .tx_valid(tx_valid), .tx_first(tx_first), .tx_last(tx_last),
        .tx_ready(tx_ready), .busy(busy), .rx_drop(rx_drop), .drop_count(drop_count)
    );

    logic [7:0] base [34] = '{8'h45, 8'h00, 8'h00, 8'h22, 8'h00, 8'h01, 8'h00, 8'h00, 8'h80, 8'h11,
                              8'h00, 8'h00, 8'hC0, 8'hA8, 8'h00, 8'h01, 8'hC0, 8'hA8, 8'h00, 8'h02,
                              8'h04, 8'hD2, 8'h16, 8'h2E, 8'h00, 8'h0E, 8'hAB, 8'hCD, 8'h01, 8'h02,
                              8'h03, 8'h04, 8'h05, 8'h06};
    logic [7:0] reply [34] = '{8'h45, 8'h00, 8'h00, 8'h22, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h11,
                               8'hF9, 8'h76, 8'hC0, 8'hA8, 8'h00, 8'h02, 8'hC0, 8'hA8, 8'h00, 8'h01,
                               8'h16, 8'h2E, 8'h04, 8'hD2, 8'h00, 8'h0E, 8'h00, 8'h00, 8'h01, 8'h02,
                               8'h03, 8'h04, 8'h05, 8'h06};
    logic [7:0] frm [64];
    logic [9:0] exp_q [$];
    int         n_cmp = 0, n_bad = 0, drop_pulses = 0;
    bit         bp_mode = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic load_base();
        for (int i = 0; i < 34; i++) frm[i] = base[i];
    endtask

    task automatic push_reply();
        for (int i = 0; i < 34; i++) exp_q.push_back({i == 0, i == 33, reply[i]});
    endtask

    task automatic send(input int n, input bit last);
        for (int i = 0; i < n; i++) begin
            rx = frm[i];
            rx_valid = 1'b1;
            rx_first = (i == 0);
            rx_last = last && (i == n - 1);
            @(posedge clk);
            #1;
        end
        rx = '0;
        rx_valid = 1'b0;
        rx_first = 1'b0;
        rx_last = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain(input string name);
        int i;
        i = 0;
        while (exp_q.size() > 0 && i < 500) begin
            @(posedge clk);
            i++;
        end
        i = 0;
        while (busy && i < 50) begin
            @(posedge clk);
            i++;
        end
        #1;
        chk({name, "_pending"}, exp_q.size(), 0);
        chk({name, "_idle"}, busy, 0);
    endtask

    task automatic chk_reset(input string name);
        chk({name, "_tx"}, tx, 0);
        chk({name, "_tx_valid"}, tx_valid, 0);
        chk({name, "_tx_first"}, tx_first, 0);
        chk({name, "_tx_last"}, tx_last, 0);
        chk({name, "_busy"}, busy, 0);
        chk({name, "_rx_drop"}, rx_drop, 0);
        chk({name, "_drop_count"}, drop_count, 0);
    endtask

    // tx_ready driver: always ready, or the 1,0,0,1 pattern during the backpressure test
    initial begin
        int k;
        k = 0;
        forever begin
            @(posedge clk);
            #1;
            if (bp_mode) begin
                tx_ready = (k % 4 == 0) || (k % 4 == 3);
                k++;
            end else tx_ready = 1'b1;
        end
    end

    // Monitor: pops the scoreboard on each handshake and checks outputs hold while stalled
    initial begin
        logic [9:0] hold;
        bit stalled;
        stalled = 1'b0;
        hold = '0;
        forever begin
            @(negedge clk);
            if (rx_drop) drop_pulses++;
            if (stalled) chk("stall_hold", {21'b0, tx_valid, tx_first, tx_last, tx}, {21'b0, 1'b1, hold});
            stalled = 1'b0;
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_tx: got byte %02h first %0b last %0b, expected no output", tx, tx_first, tx_last);
                end else chk("tx_byte", {22'b0, tx_first, tx_last, tx}, {22'b0, exp_q.pop_front()});
            end else if (tx_valid) begin
                stalled = 1'b1;
                hold = {tx_first, tx_last, tx};
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        cycles(3);
        chk_reset("reset");
        reset_n = 1'b1;
        cycles(1);

        load_base();
        push_reply();
        send(34, 1'b1);
        chk("lat_csum_valid", tx_valid, 0);
        chk("lat_busy", busy, 1);
        cycles(1);
        chk("lat_send_valid", tx_valid, 0);
        cycles(1);
        chk("lat_first_valid", tx_valid, 1);
        chk("lat_first_flag", tx_first, 1);
        chk("lat_first_byte", tx, 8'h45);
        drain("basic");
        chk("basic_drops", drop_count, 0);

        bp_mode = 1'b1;
        push_reply();
        send(34, 1'b1);
        drain("backpressure");
        bp_mode = 1'b0;
        cycles(2);

        load_base();
        frm[9] = 8'h06;
        send(34, 1'b1);
        cycles(3);
        load_base();
        frm[3] = 8'h23;
        send(34, 1'b1);
        cycles(3);
        load_base();
        send(20, 1'b1);
        cycles(3);
        chk("reject_drop_count", drop_count, 3);
        chk("reject_pulses", drop_pulses, 3);
        chk("reject_idle", busy, 0);

        load_base();
        send(10, 1'b0);
        push_reply();
        send(34, 1'b1);
        drain("restart");
        chk("restart_drop_count", drop_count, 4);
        chk("restart_pulses", drop_pulses, 4);

        push_reply();
        send(34, 1'b1);
        cycles(6);
        rx = 8'h45;
        rx_valid = 1'b1;
        rx_first = 1'b1;
        cycles(1);
        rx = '0;
        rx_valid = 1'b0;
        rx_first = 1'b0;
        drain("collision");
        chk("collision_drop_count", drop_count, 5);
        chk("collision_pulses", drop_pulses, 5);

        push_reply();
        send(34, 1'b1);
        cycles(17);
        chk("rst_pre_byte15", tx, reply[15]);
        reset_n = 1'b0;
        cycles(1);
        chk_reset("rst_mid");
        reset_n = 1'b1;
        exp_q.delete();
        cycles(2);
        push_reply();
        send(34, 1'b1);
        drain("after_reset");
        chk("after_reset_drops", drop_count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
